// File: rtl/uart_pkg.sv
// Shared UART constants: baud divider math, counter sizing, rx FSM states.
package uart_pkg;

  function automatic int uart_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int uart_half(input int div);
    return div / 2;
  endfunction

  function automatic int uart_cnt_w(input int div);
    int w;
    w = uart_clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// User-side receive bundle: byte, one-cycle valid strobe, framing-error strobe.
interface uart_rx_if #(
  parameter int P_DATA_WIDTH = 8
) ();
  logic [P_DATA_WIDTH-1:0] data;
  logic                    valid;
  logic                    frame_err;

  modport master (
    output data,
    output valid,
    output frame_err
  );

  modport slave (
    input data,
    input valid,
    input frame_err
  );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync_2ff #(
  parameter logic P_RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= P_RST_VAL;
      sync_q <= P_RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB-first, one-cycle valid strobe.
// Define UART_RX_FRAME_ERR_EN to add the o_user_rx_frame_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                         o_user_rx_frame_err
`endif
);
  localparam int DIV  = uart_div(P_SYSTEM_CLK, P_UART_BUADRATE);
  localparam int HALF = uart_half(DIV);
  localparam int CW   = uart_cnt_w(DIV);
  localparam int W    = P_UART_DATA_WIDTH;
  localparam int IW   = uart_cnt_w(W);

  if (P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2 ||
      W < 5 || W > 9) begin : g_bad_cfg
    $error("uart_rx: unsupported frame format");
  end

  uart_rx_state_e state_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   shift_q;
  logic [W-1:0]   data_q;
  logic           valid_q;
  logic           ferr_q;
  logic           prev_q;
  logic           line_s;

  uart_sync_2ff #(
    .P_RST_VAL(1'b1)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_uart_rx),
    .o_q  (line_s)
  );

  // Only the first stop bit is sampled; returning to idle at mid-stop
  // leaves the rest of the stop time free for the next start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      prev_q  <= line_s;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (prev_q && !line_s) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= line_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_q   <= '0;
            shift_q <= {line_s, shift_q[W-1:1]};
            if (idx_q == IW'(W - 1)) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_q <= '0;
            if (line_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (line_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_user_rx_data  = data_q;
  assign o_user_rx_valid = valid_q;

`ifdef UART_RX_FRAME_ERR_EN
  assign o_user_rx_frame_err = ferr_q;
`else
  logic unused_ferr;
  assign unused_ferr = ferr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frame-level model with expected byte/time queue.
module tb_uart_rx;
  localparam int SYS  = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int DIV  = SYS / BAUD;
  localparam int HALF = DIV / 2;

  logic   clk   = 1'b0;
  logic   rst   = 1'b1;
  logic   line0 = 1'b1;
  logic   line7 = 1'b1;
  longint cyc   = 0;

  uart_rx_if #(.P_DATA_WIDTH(8)) u_if ();
  uart_rx_if #(.P_DATA_WIDTH(7)) u_if7 ();

  uart_rx #(
    .P_SYSTEM_CLK(SYS), .P_UART_BUADRATE(BAUD),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(line0),
    .o_user_rx_data(u_if.data),
    .o_user_rx_valid(u_if.valid)
`ifdef UART_RX_FRAME_ERR_EN
    , .o_user_rx_frame_err(u_if.frame_err)
`endif
  );

  uart_rx #(
    .P_SYSTEM_CLK(SYS), .P_UART_BUADRATE(BAUD),
    .P_UART_DATA_WIDTH(7), .P_UART_STOP_WIDTH(2)
  ) dut7 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(line7),
    .o_user_rx_data(u_if7.data),
    .o_user_rx_valid(u_if7.valid)
`ifdef UART_RX_FRAME_ERR_EN
    , .o_user_rx_frame_err(u_if7.frame_err)
`endif
  );

`ifndef UART_RX_FRAME_ERR_EN
  assign u_if.frame_err  = 1'b0;
  assign u_if7.frame_err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] d;
    longint     t;
  } exp_t;

  exp_t q0[$];
  exp_t q7[$];
  int checks = 0, errors = 0;
  int pulses0 = 0, pulses7 = 0, ferr_cnt = 0, ferr_exp = 0;
  bit pv0 = 0, pv7 = 0;

  function automatic void chk(string n, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, got, want);
    end
  endfunction

  function automatic void flag(string n);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", n, cyc);
  endfunction

  always @(negedge clk) begin : cmp0
    exp_t e;
    if (!rst) begin
      if (u_if.valid) begin
        pulses0++;
        chk("v0_single", pv0, 0);
        if (q0.size() == 0) flag("v0_spurious");
        else begin
          e = q0.pop_front();
          chk("v0_data", u_if.data, e.d[7:0]);
          chk("v0_time", (cyc >= e.t - 1 && cyc <= e.t + 1), 1);
        end
      end else if (q0.size() > 0 && cyc > q0[0].t + 1) begin
        flag("v0_missed");
        void'(q0.pop_front());
      end
      if (u_if.frame_err) ferr_cnt++;
      pv0 = u_if.valid;
    end
  end

  always @(negedge clk) begin : cmp7
    exp_t e;
    if (!rst) begin
      if (u_if7.valid) begin
        pulses7++;
        chk("v7_single", pv7, 0);
        if (q7.size() == 0) flag("v7_spurious");
        else begin
          e = q7.pop_front();
          chk("v7_data", u_if7.data, e.d[6:0]);
          chk("v7_time", (cyc >= e.t - 1 && cyc <= e.t + 1), 1);
        end
      end else if (q7.size() > 0 && cyc > q7[0].t + 1) begin
        flag("v7_missed");
        void'(q7.pop_front());
      end
      pv7 = u_if7.valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv(input int sel, input logic b);
    if (sel == 0) line0 = b;
    else line7 = b;
  endtask

  // Frame on the wire; a good frame is expected about
  // 3 sync cycles + HALF + (w+1)*DIV + 1 after its falling edge.
  task automatic send(input int sel, input logic [8:0] d, input int w,
                      input int ns, input logic ok);
    exp_t e;
    e.d = d;
    e.t = cyc + 3 + HALF + (w + 1) * DIV + 1;
    if (ok) begin
      if (sel == 0) q0.push_back(e);
      else q7.push_back(e);
    end else if (sel == 0) begin
      ferr_exp++;
    end
    drv(sel, 1'b0);
    tick(DIV);
    for (int i = 0; i < w; i++) begin
      drv(sel, d[i]);
      tick(DIV);
    end
    drv(sel, ok);
    tick(DIV);
    for (int i = 1; i < ns; i++) begin
      drv(sel, 1'b1);
      tick(DIV);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p, f, r;
    logic [8:0] rd;
    logic [7:0] c5;
    tick(3);
    @(negedge clk);
    chk("rst_data", u_if.data, 0);
    chk("rst_valid", u_if.valid, 0);
    chk("rst_data7", u_if7.data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(5);

    p = pulses0;
    send(0, 9'h55, 8, 1, 1'b1);
    tick(100);
    chk("t1_pulses", pulses0 - p, 1);
    chk("t1_hold", u_if.data, 8'h55);

    p = pulses0;
    send(0, 9'hA3, 8, 1, 1'b1);
    send(0, 9'h00, 8, 1, 1'b1);
    send(0, 9'hFF, 8, 1, 1'b1);
    tick(20);
    chk("t2_pulses", pulses0 - p, 3);
    chk("t2_last", u_if.data, 8'hFF);

    p = pulses0;
    drv(0, 1'b0);
    tick(3);
    drv(0, 1'b1);
    tick(15);
    chk("t3_glitch", pulses0 - p, 0);
    send(0, 9'h3C, 8, 1, 1'b1);
    tick(20);
    chk("t3_pulses", pulses0 - p, 1);
    chk("t3_data", u_if.data, 8'h3C);

    p = pulses0;
    f = ferr_cnt;
    send(0, 9'h81, 8, 1, 1'b0);
    tick(40);
    drv(0, 1'b1);
    tick(5);
    chk("t4_nopulse", pulses0 - p, 0);
`ifdef UART_RX_FRAME_ERR_EN
    chk("t4_ferr", ferr_cnt - f, 1);
`endif
    send(0, 9'h7E, 8, 1, 1'b1);
    tick(20);
    chk("t4_data", u_if.data, 8'h7E);

    p = pulses0;
    c5 = 8'hC5;
    drv(0, 1'b0);
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      drv(0, c5[i]);
      tick(DIV);
    end
    drv(0, c5[4]);
    tick(3);
    rst = 1'b1;
    drv(0, 1'b1);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_data", u_if.data, 0);
    chk("t5_rst_valid", u_if.valid, 0);
    tick(5);
    send(0, 9'h12, 8, 1, 1'b1);
    tick(20);
    chk("t5_pulses", pulses0 - p, 1);
    chk("t5_data", u_if.data, 8'h12);

    p = pulses7;
    send(1, 9'h5A, 7, 2, 1'b1);
    chk("t6_first", u_if7.data, 7'h5A);
    send(1, 9'h21, 7, 2, 1'b1);
    tick(20);
    chk("t6_pulses", pulses7 - p, 2);
    chk("t6_last", u_if7.data, 7'h21);

    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        drv(0, 1'b0);
        tick($urandom_range(1, 3));
        drv(0, 1'b1);
        tick(12);
      end else if (r == 1) begin
        rd = 9'($urandom_range(0, 255));
        send(0, rd, 8, 1, 1'b0);
        tick($urandom_range(0, 30));
        drv(0, 1'b1);
        tick($urandom_range(2, 6));
      end else begin
        rd = 9'($urandom_range(0, 255));
        send(0, rd, 8, 1, 1'b1);
        tick($urandom_range(0, 3));
      end
    end
    repeat (8) begin
      rd = 9'($urandom_range(0, 127));
      send(1, rd, 7, 2, 1'b1);
      tick($urandom_range(0, 2));
    end

    tick(120);
    chk("q0_drained", q0.size(), 0);
    chk("q7_drained", q7.size(), 0);
`ifdef UART_RX_FRAME_ERR_EN
    chk("ferr_total", ferr_cnt, ferr_exp);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
